squeeze_serializer: RTL and testbench

Squeeze-side output stage of the Haraka-S sponge: the transmit counterpart of the absorb-side deserializer. It takes 256-bit rate blocks from the permutation datapath and emits exactly `ceil(digest_length/8)` digest bytes on a byte-wide valid/ready stream. The final byte is masked when `digest_length` is not a multiple of 8. Between blocks it pulses `perm_req` so the sponge core runs one more permutation and presents the next rate block.

---
 rtl/squeeze_serializer.sv | 142 ++++++++++++++
 tb/tb_squeeze_serializer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/squeeze_serializer.sv
// Squeeze-side output stage of the Haraka-S sponge.
// Accepts rate blocks from the permutation datapath and streams the digest
// out byte by byte, masking the final byte when the bit length is not a
// whole number of bytes. Pulses perm_req between blocks.
module squeeze_serializer #(
    parameter int unsigned BLOCK_BYTES = 32,
    parameter int unsigned LEN_W       = 64
) (
    input  logic                     internal_clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [LEN_W-1:0]         digest_length,
    input  logic [8*BLOCK_BYTES-1:0] block_in,
    input  logic                     block_valid,
    output logic                     block_ready,
    output logic                     perm_req,
    output logic [7:0]               serial_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned BlkW = 8 * BLOCK_BYTES;
    localparam int unsigned RemW = LEN_W - 2;

    typedef enum logic [2:0] {
        StIdle,
        StWaitBlk,
        StShift,
        StReq,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [BlkW-1:0] shreg_q;
    logic [RemW-1:0] rem_bytes_q;
    logic [5:0]      blk_bytes_q;
    logic [2:0]      tail_bits_q;

    logic [RemW-1:0] rem_load;
    logic [5:0]      blk_load;
    logic            blk_fire;
    logic            byte_fire;
    logic            last_byte;
    logic [7:0]      head_byte;
    logic [7:0]      tail_mask;

    // Byte count is formed one bit wider than the length so all-ones cannot wrap.
    assign rem_load  = RemW'(({1'b0, digest_length} + (LEN_W + 1)'(7)) >> 3);
    assign blk_load  = (rem_bytes_q < RemW'(BLOCK_BYTES)) ? rem_bytes_q[5:0] : 6'(BLOCK_BYTES);
    assign blk_fire  = (state_q == StWaitBlk) && block_valid;
    assign byte_fire = (state_q == StShift) && out_ready;
    assign last_byte = (rem_bytes_q == RemW'(1));
    assign head_byte = shreg_q[BlkW-1 -: 8];
    // Keep only the upper tail_bits bits of the final byte.
    assign tail_mask = (last_byte && (tail_bits_q != 3'd0)) ? ~(8'hFF >> tail_bits_q) : 8'hFF;

    // State register.
    always_ff @(posedge internal_clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (digest_length != '0) ? StWaitBlk : StDone;
                end
            end
            StWaitBlk: begin
                if (block_valid) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (out_ready) begin
                    if (last_byte) begin
                        state_d = StDone;
                    end else if (blk_bytes_q == 6'd1) begin
                        state_d = StReq;
                    end
                end
            end
            StReq:   state_d = StWaitBlk;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        block_ready = 1'b0;
        perm_req    = 1'b0;
        out_valid   = 1'b0;
        serial_out  = 8'h00;
        done        = 1'b0;
        busy        = (state_q != StIdle);
        unique case (state_q)
            StWaitBlk: block_ready = 1'b1;
            StShift: begin
                out_valid  = 1'b1;
                serial_out = head_byte & tail_mask;
            end
            StReq:   perm_req = 1'b1;
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: length capture, block load and byte shifting.
    always_ff @(posedge internal_clk or posedge reset) begin
        if (reset) begin
            shreg_q     <= '0;
            rem_bytes_q <= '0;
            blk_bytes_q <= '0;
            tail_bits_q <= '0;
        end else begin
            if ((state_q == StIdle) && start && (digest_length != '0)) begin
                rem_bytes_q <= rem_load;
                tail_bits_q <= digest_length[2:0];
            end
            if (blk_fire) begin
                shreg_q     <= block_in;
                blk_bytes_q <= blk_load;
            end
            if (byte_fire) begin
                shreg_q     <= {shreg_q[BlkW-9:0], 8'h00};
                rem_bytes_q <= rem_bytes_q - RemW'(1);
                blk_bytes_q <= blk_bytes_q - 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_squeeze_serializer.sv
// Self-checking bench for squeeze_serializer: scenario tasks driven against a
// byte-level reference model built from the digest length and rate blocks.
module tb_squeeze_serializer;

    logic         internal_clk;
    logic         reset;
    logic         start;
    logic [63:0]  digest_length;
    logic [255:0] block_in;
    logic         block_valid;
    logic         block_ready;
    logic         perm_req;
    logic [7:0]   serial_out;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         done;

    int n_checks;
    int n_errors;

    logic [255:0] blocks [4];

    squeeze_serializer dut (
        .internal_clk  (internal_clk),
        .reset         (reset),
        .start         (start),
        .digest_length (digest_length),
        .block_in      (block_in),
        .block_valid   (block_valid),
        .block_ready   (block_ready),
        .perm_req      (perm_req),
        .serial_out    (serial_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .done          (done)
    );

    initial internal_clk = 1'b0;
    always #5 internal_clk = ~internal_clk;

    task automatic fill_random_blocks();
        for (int k = 0; k < 4; k++) begin
            blocks[k] = {$urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom};
        end
    endtask

    // Runs one digest end to end. mode 0: ready always; 1: ready 1,0,0,1 pattern;
    // 2: random ready and random block_valid. poke pulses start while busy.
    task automatic run_digest(input string name, input int len, input int mode, input bit poke);
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        logic [7:0] b;
        logic [7:0] held_byte;
        int total, exp_perm, perm_cnt, blk_idx, last_fire, pat, tail;
        bit prev_perm, prev_acc, held, done_seen;

        total = (len + 7) / 8;
        tail  = len % 8;
        for (int i = 0; i < total; i++) begin
            b = blocks[i / 32][255 - 8 * (i % 32) -: 8];
            if (i == total - 1 && tail != 0) b = b & 8'(255 << (8 - tail));
            exp_q.push_back(b);
        end
        exp_perm = (total == 0) ? 0 : (total - 1) / 32;

        perm_cnt = 0; blk_idx = 0; last_fire = -1; pat = 0;
        prev_perm = 0; prev_acc = 0; held = 0; done_seen = 0; held_byte = 8'h00;

        @(negedge internal_clk);
        start = 1'b1; digest_length = 64'(len); out_ready = 1'b0; block_valid = 1'b0;
        @(negedge internal_clk);
        start = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 0 && len != 0) begin
                n_checks++;
                if (block_ready !== 1'b1) begin
                    n_errors++;
                    $display("FAIL %s start_to_ready: block_ready=%b expected 1", name, block_ready);
                end
            end
            if (prev_perm) begin
                n_checks++;
                if (block_ready !== 1'b1) begin
                    n_errors++;
                    $display("FAIL %s perm_then_ready: block_ready=%b expected 1", name, block_ready);
                end
            end
            if (prev_acc) begin
                n_checks++;
                if (out_valid !== 1'b1) begin
                    n_errors++;
                    $display("FAIL %s first_byte_latency: out_valid=%b expected 1", name, out_valid);
                end
            end
            if (held) begin
                n_checks++;
                if (out_valid !== 1'b1 || serial_out !== held_byte) begin
                    n_errors++;
                    $display("FAIL %s stall_hold: valid=%b byte=%h expected 1/%h",
                             name, out_valid, serial_out, held_byte);
                end
            end
            if (perm_req === 1'b1) perm_cnt++;
            if (done === 1'b1) begin
                n_checks++;
                if (cyc != last_fire + 1) begin
                    n_errors++;
                    $display("FAIL %s done_timing: done at cycle %0d expected %0d",
                             name, cyc, last_fire + 1);
                end
                done_seen = 1;
                break;
            end

            start = poke && (cyc == 3);
            if (poke && cyc == 3) digest_length = 64'd8;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (pat % 4 == 0) || (pat % 4 == 3);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            pat++;
            block_valid = (mode == 2) ? 1'($urandom_range(0, 1)) : block_ready;
            block_in    = blocks[blk_idx < 4 ? blk_idx : 0];
            prev_acc    = block_valid && block_ready;
            if (prev_acc) blk_idx++;
            held      = out_valid && !out_ready;
            held_byte = serial_out;
            if (out_valid && out_ready) begin
                got_q.push_back(serial_out);
                if (got_q.size() == total) last_fire = cyc;
            end
            prev_perm = perm_req;
            @(negedge internal_clk);
        end
        start = 1'b0; block_valid = 1'b0; out_ready = 1'b0;

        n_checks++;
        if (!done_seen) begin
            n_errors++;
            $display("FAIL %s done_timeout: done=0 expected 1 within budget", name);
        end else begin
            @(negedge internal_clk);
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_errors++;
                $display("FAIL %s back_to_idle: busy=%b done=%b expected 0/0", name, busy, done);
            end
        end

        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL %s byte_count: got %0d expected %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL %s byte[%0d]: got %h expected %h", name, i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (perm_cnt != exp_perm) begin
            n_errors++;
            $display("FAIL %s perm_count: got %0d expected %0d", name, perm_cnt, exp_perm);
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({block_ready, perm_req, out_valid, busy, done, serial_out} !== 13'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: ready=%b perm=%b valid=%b busy=%b done=%b byte=%h expected all 0",
                     block_ready, perm_req, out_valid, busy, done, serial_out);
        end
        @(negedge internal_clk);
        @(negedge internal_clk);
        reset = 1'b0;
        @(negedge internal_clk);
        n_checks++;
        if ({block_ready, busy, done, out_valid} !== 4'h0) begin
            n_errors++;
            $display("FAIL idle_after_reset: ready=%b busy=%b done=%b valid=%b expected 0",
                     block_ready, busy, done, out_valid);
        end
    endtask

    task automatic test_single_block();
        for (int i = 0; i < 32; i++) blocks[0][255 - 8 * i -: 8] = 8'(i);
        run_digest("single_block", 256, 0, 0);
    endtask

    task automatic test_partial_tail();
        fill_random_blocks();
        blocks[0][255:232] = 24'hABCDEF;
        run_digest("partial_tail", 20, 0, 0);
    endtask

    task automatic test_multi_block();
        fill_random_blocks();
        run_digest("multi_block", 600, 0, 0);
    endtask

    task automatic test_backpressure();
        fill_random_blocks();
        run_digest("backpressure", 600, 1, 0);
    endtask

    task automatic test_zero_len();
        run_digest("zero_len", 0, 0, 0);
    endtask

    task automatic test_start_busy();
        fill_random_blocks();
        run_digest("start_busy", 300, 0, 1);
    endtask

    task automatic test_reset_mid();
        int cnt;
        fill_random_blocks();
        cnt = 0;
        @(negedge internal_clk);
        start = 1'b1; digest_length = 64'd256; out_ready = 1'b1;
        @(negedge internal_clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 200 && cnt < 10; cyc++) begin
            if (out_valid) cnt++;
            block_valid = block_ready;
            block_in    = blocks[0];
            @(negedge internal_clk);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({block_ready, perm_req, out_valid, busy, done, serial_out} !== 13'h0 || cnt != 10) begin
            n_errors++;
            $display("FAIL reset_mid: bytes=%0d ready=%b valid=%b busy=%b done=%b byte=%h expected 10 and all 0",
                     cnt, block_ready, out_valid, busy, done, serial_out);
        end
        @(negedge internal_clk);
        reset = 1'b0; block_valid = 1'b0; out_ready = 1'b0;
        run_digest("after_reset", 16, 0, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 12; t++) begin
            fill_random_blocks();
            run_digest("random", $urandom_range(0, 760), 2, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        reset = 1'b1; start = 1'b0; digest_length = '0; block_in = '0;
        block_valid = 1'b0; out_ready = 1'b0;
        test_reset();
        test_single_block();
        test_partial_tail();
        test_multi_block();
        test_backpressure();
        test_zero_len();
        test_start_busy();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
